// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: a small FIFO feeds a start/data/stop serialiser.
// Bit timing comes from an internal baud down-count on clk; data_t is fully registered.
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 10417,
  parameter int FIFO_AW      = 3,
  parameter int STOP_BITS    = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [7:0]         tx_data,
  input  logic               tx_valid,
  output logic               tx_ready,
  output logic               data_t,
  output logic               busy,
  output logic [FIFO_AW:0]   fifo_count
);

  // state | meaning
  // IDLE  | line high, waiting for a queued byte
  // START | start bit (low)
  // DATA  | data bits, LSB first
  // STOP  | stop bit(s); pops the next byte back-to-back at the end
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  localparam int                 DEPTH    = 2 ** FIFO_AW;
  localparam int                 BW       = $clog2(CLKS_PER_BIT);
  localparam logic [FIFO_AW:0]   FULL_CNT = (FIFO_AW + 1)'(DEPTH);
  localparam logic [BW-1:0]      BAUD_MAX = BW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]         STOP_MAX = 3'(STOP_BITS - 1);

  logic [7:0]         mem_q [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [FIFO_AW:0]   count_q, count_d;

  state_t             state_q;
  logic [BW-1:0]      baud_q;
  logic [2:0]         bit_idx_q;
  logic [7:0]         shift_q;
  logic               data_t_q, busy_q;

  logic push, pop, baud_done, last_stop;

  assign tx_ready   = (count_q != FULL_CNT);
  assign fifo_count = count_q;
  assign data_t     = data_t_q;
  assign busy       = busy_q;

  assign push      = tx_valid && tx_ready;
  assign baud_done = (baud_q == BAUD_MAX);
  assign last_stop = (bit_idx_q == STOP_MAX);
  assign pop       = (count_q != '0) &&
                     ((state_q == S_IDLE) || (state_q == S_STOP && baud_done && last_stop));

  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (!push && pop) count_d = count_q - 1'b1;
  end

  // Storage has no reset; only pointers and count are cleared.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= tx_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      baud_q    <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      data_t_q  <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          baud_q    <= '0;
          bit_idx_q <= '0;
          if (pop) begin
            shift_q  <= mem_q[rd_ptr_q];
            state_q  <= S_START;
            data_t_q <= 1'b0;
            busy_q   <= 1'b1;
          end
        end
        S_START: begin
          if (baud_done) begin
            baud_q    <= '0;
            bit_idx_q <= '0;
            state_q   <= S_DATA;
            data_t_q  <= shift_q[0];
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        S_DATA: begin
          if (baud_done) begin
            baud_q <= '0;
            if (bit_idx_q == 3'd7) begin
              bit_idx_q <= '0;
              state_q   <= S_STOP;
              data_t_q  <= 1'b1;
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
              shift_q   <= shift_q >> 1;
              data_t_q  <= shift_q[1];
            end
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        S_STOP: begin
          if (baud_done) begin
            baud_q <= '0;
            // bit_idx_q doubles as the stop-bit counter here
            if (!last_stop) begin
              bit_idx_q <= bit_idx_q + 3'd1;
            end else if (pop) begin
              bit_idx_q <= '0;
              shift_q   <= mem_q[rd_ptr_q];
              state_q   <= S_START;
              data_t_q  <= 1'b0;
            end else begin
              bit_idx_q <= '0;
              state_q   <= S_IDLE;
              busy_q    <= 1'b0;
            end
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        default: begin
          state_q  <= S_IDLE;
          data_t_q <= 1'b1;
          busy_q   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: queue-based frame model checked every cycle, table-driven
// frame vectors, directed corner sequences, random traffic, and a 2-stop-bit instance.
module tb_uart_tx_fifo;

  localparam int CPB   = 4;
  localparam int AW    = 3;
  localparam int DEPTH = 8;
  localparam int FRAME = 10 * CPB;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready, data_t, busy;
  logic [AW:0] fifo_count;

  logic [7:0] d2;
  logic       v2;
  logic       tx_ready2, data_t2, busy2;
  logic [AW:0] fifo_count2;

  int total = 0;
  int bad   = 0;
  bit mon_en = 1'b0;

  always #5 clk = ~clk;

  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_AW(AW), .STOP_BITS(1)) dut (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .data_t(data_t), .busy(busy), .fifo_count(fifo_count));

  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_AW(AW), .STOP_BITS(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .tx_data(d2), .tx_valid(v2),
    .tx_ready(tx_ready2), .data_t(data_t2), .busy(busy2), .fifo_count(fifo_count2));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: queue of waiting bytes plus position within the current frame.
  logic [7:0] q[$];
  logic [7:0] cur;
  int         pos = -1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      pos = -1;
    end else begin
      bit do_push, do_pop;
      do_push = tx_valid && (q.size() != DEPTH);
      do_pop  = 1'b0;
      if (pos < 0) begin
        if (q.size() != 0) do_pop = 1'b1;
      end else begin
        pos++;
        if (pos == FRAME) begin
          if (q.size() != 0) do_pop = 1'b1;
          else pos = -1;
        end
      end
      if (do_pop) begin
        cur = q.pop_front();
        pos = 0;
      end
      if (do_push) q.push_back(tx_data);
    end
  end

  function automatic logic exp_line();
    int k;
    if (pos < 0) return 1'b1;
    k = pos / CPB;
    if (k == 0) return 1'b0;
    if (k <= 8) return cur[k-1];
    return 1'b1;
  endfunction

  always @(negedge clk) begin
    if (mon_en) begin
      chk("m_line",  32'(data_t),     32'(exp_line()));
      chk("m_busy",  32'(busy),       32'(pos >= 0));
      chk("m_count", 32'(fifo_count), 32'(q.size()));
      chk("m_ready", 32'(tx_ready),   32'(q.size() != DEPTH));
    end
  end

  typedef struct {
    logic [7:0] data;
    logic [9:0] levels;
  } vec_t;
  vec_t vecs[4];

  task automatic send_check(input logic [7:0] b, input logic [9:0] lv);
    tx_valid = 1'b1;
    tx_data  = b;
    @(negedge clk);
    tx_valid = 1'b0;
    chk("sc_pre_line", 32'(data_t), 32'h1);
    chk("sc_pre_busy", 32'(busy), 32'h0);
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk);
      chk("sc_line", 32'(data_t), 32'(lv[i / CPB]));
      chk("sc_busy", 32'(busy), 32'h1);
    end
    @(negedge clk);
    chk("sc_end_busy", 32'(busy), 32'h0);
    chk("sc_end_line", 32'(data_t), 32'h1);
  endtask

  task automatic drain();
    int n = 0;
    while ((busy || fifo_count != 0) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", 32'(n < 2000), 32'h1);
  endtask

  task automatic push_n(input logic [7:0] base, input int count);
    int acc = 0;
    int guard = 0;
    tx_valid = 1'b1;
    tx_data  = base;
    while (acc < count && guard < 2000) begin
      bit took;
      took = tx_ready;
      @(negedge clk);
      guard++;
      if (took) begin
        acc++;
        tx_data = base + 8'(acc);
      end
    end
    tx_valid = 1'b0;
    chk("push_timeout", 32'(guard < 2000), 32'h1);
  endtask

  initial begin
    int n;
    bit saw_full;
    rst_n = 1'b0; tx_valid = 1'b0; tx_data = 8'h00; v2 = 1'b0; d2 = 8'h00;

    vecs[0] = '{8'hA5, 10'b1101001010};
    vecs[1] = '{8'h00, 10'b1000000000};
    vecs[2] = '{8'hFF, 10'b1111111110};
    vecs[3] = '{8'h5A, 10'b1010110100};

    // reset held for 5 cycles
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("rst_line",  32'(data_t), 32'h1);
      chk("rst_busy",  32'(busy), 32'h0);
      chk("rst_ready", 32'(tx_ready), 32'h1);
      chk("rst_count", 32'(fifo_count), 32'h0);
    end
    rst_n = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);

    // single frames from the vector table
    for (int i = 0; i < 4; i++) send_check(vecs[i].data, vecs[i].levels);

    // 16 bytes with valid held, advancing only on accept
    saw_full = 1'b0;
    begin
      int acc = 0;
      int guard = 0;
      tx_valid = 1'b1;
      tx_data  = 8'h00;
      while (acc < 16 && guard < 2000) begin
        bit took;
        took = tx_ready;
        if (fifo_count == 4'(DEPTH) && !tx_ready) saw_full = 1'b1;
        @(negedge clk);
        guard++;
        if (took) begin
          acc++;
          tx_data = 8'(acc);
        end
      end
      tx_valid = 1'b0;
      chk("seq16_timeout", 32'(guard < 2000), 32'h1);
    end
    chk("seq16_saw_full", 32'(saw_full), 32'h1);
    drain();

    // full FIFO: push refused on the pop edge, accepted on the next
    push_n(8'h10, 9);
    chk("full_count", 32'(fifo_count), 32'h8);
    chk("full_ready", 32'(tx_ready), 32'h0);
    tx_valid = 1'b1;
    tx_data  = 8'hEE;
    n = 0;
    while (fifo_count == 4'(DEPTH) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("full_wait_timeout", 32'(n < 200), 32'h1);
    chk("full_pop_count", 32'(fifo_count), 32'h7);
    chk("full_pop_ready", 32'(tx_ready), 32'h1);
    @(negedge clk);
    tx_valid = 1'b0;
    chk("full_refill_count", 32'(fifo_count), 32'h8);
    chk("full_refill_ready", 32'(tx_ready), 32'h0);
    drain();

    // random traffic against the model
    for (int i = 0; i < 800; i++) begin
      tx_valid = ($urandom_range(0, 3) == 0);
      tx_data  = 8'($urandom);
      @(negedge clk);
    end
    tx_valid = 1'b0;
    drain();

    // async reset in the middle of DATA bit 3
    push_n(8'hA5, 1);
    push_n(8'h11, 2);
    n = 0;
    while (!(pos >= 16 && pos <= 19) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("midrst_wait_timeout", 32'(n < 200), 32'h1);
    chk("midrst_line_before", 32'(data_t), 32'h0);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_line", 32'(data_t), 32'h1);
    chk("midrst_count", 32'(fifo_count), 32'h0);
    chk("midrst_busy", 32'(busy), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send_check(8'h3C, 10'b1001111000);

    // two stop bits: 0xFF then 0x00
    v2 = 1'b1;
    d2 = 8'hFF;
    @(negedge clk);
    d2 = 8'h00;
    @(negedge clk);
    v2 = 1'b0;
    n = 0;
    while (data_t2 === 1'b0 && n < 200) begin n++; @(negedge clk); end
    chk("sb2_start_len", 32'(n), 32'(CPB));
    n = 0;
    while (data_t2 === 1'b1 && n < 200) begin n++; @(negedge clk); end
    chk("sb2_ff_high_len", 32'(n), 32'(8 * CPB + 2 * CPB));
    n = 0;
    while (data_t2 === 1'b0 && n < 200) begin n++; @(negedge clk); end
    chk("sb2_00_low_len", 32'(n), 32'(9 * CPB));
    n = 0;
    while (data_t2 === 1'b1 && busy2 && n < 200) begin n++; @(negedge clk); end
    chk("sb2_stop_len", 32'(n), 32'(2 * CPB));
    chk("sb2_idle_busy", 32'(busy2), 32'h0);
    chk("sb2_idle_line", 32'(data_t2), 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
